// File: rtl/npu_ctrl_pkg.sv
// Shared definitions for the inference-pipeline layer controllers.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package npu_ctrl_pkg;

    // Default widths, shared with the other layer controllers.
    localparam int DEF_TMO_W = 16;
    localparam int DEF_CNT_W = 24;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ERR    = 2'd3
    } seq_state_t;

    // Width of an index into n items. A single item still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_next_idx.sv
// Finds the lowest set mask bit strictly above cur, or the lowest set bit overall when incl_all is set.
// Latency: purely combinational.
// Backpressure: none; found is low when no candidate bit exists and nxt is then 0.
module prio_next_idx
    import npu_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         mask,
    input  logic [idx_w(N)-1:0]  cur,
    input  logic                 incl_all,
    output logic [idx_w(N)-1:0]  nxt,
    output logic                 found
);

    localparam int IW = idx_w(N);

    // Scan from the top down so that the lowest qualifying bit is the one left standing.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (incl_all || (i > int'(cur)))) begin
                nxt   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_seq_ctrl.sv
// Launches the enabled compute stages one after another and collects the last stage's result.
// Latency: strobe 1 cycle after a start edge, next strobe 1 cycle after each done, run done 2 cycles after the last done.
// Backpressure: none; start edges while busy are dropped, and only the running stage's done is honoured.
module layer_seq_ctrl
    import npu_ctrl_pkg::*;
#(
    parameter int N_STAGES = 4,
    parameter int TMO_W    = DEF_TMO_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int RES_W    = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [N_STAGES-1:0]          stage_en,
    input  logic [TMO_W-1:0]             timeout_lim,
    input  logic [N_STAGES-1:0]          stage_done,
    input  logic [RES_W-1:0]             res_in,
    output logic [N_STAGES-1:0]          stage_start,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [idx_w(N_STAGES)-1:0]   err_stage,
    output logic                         aborted,
    output logic [RES_W-1:0]             out,
    input  logic [idx_w(N_STAGES)-1:0]   perf_sel,
    output logic [CNT_W-1:0]             perf_cnt
);

    localparam int IW = idx_w(N_STAGES);

    seq_state_t            state_q, state_d;
    logic                  start_q;
    logic                  start_edge;
    logic [N_STAGES-1:0]   en_q;
    logic [IW-1:0]         k_q;
    logic [TMO_W-1:0]      wdog_q;
    logic [CNT_W-1:0]      perf_q [N_STAGES];
    logic                  fin_q;

    logic [IW-1:0]         first_idx, adv_idx;
    logic                  first_found, adv_found;
    logic                  done_k;

    // One-cycle decisions taken by the FSM this cycle.
    logic                  launch_run, empty_run, finish, advance, tmo_hit, abort_hit;

    assign start_edge = start & ~start_q;
    assign done_k     = stage_done[k_q];

    // First stage of a run comes straight from the live mask, since it is latched on the same edge.
    prio_next_idx #(.N(N_STAGES)) u_first (
        .mask     (stage_en),
        .cur      ('0),
        .incl_all (1'b1),
        .nxt      (first_idx),
        .found    (first_found)
    );

    prio_next_idx #(.N(N_STAGES)) u_adv (
        .mask     (en_q),
        .cur      (k_q),
        .incl_all (1'b0),
        .nxt      (adv_idx),
        .found    (adv_found)
    );

    // Next-state and per-cycle decision logic; abort outranks done and watchdog while a run is active.
    always_comb begin
        state_d    = state_q;
        launch_run = 1'b0;
        empty_run  = 1'b0;
        finish     = 1'b0;
        advance    = 1'b0;
        tmo_hit    = 1'b0;
        abort_hit  = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start_edge) begin
                    if (first_found) begin
                        launch_run = 1'b1;
                        state_d    = ST_LAUNCH;
                    end else begin
                        empty_run  = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_LAUNCH: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_d   = ST_IDLE;
                end else if (done_k) begin
                    if (adv_found) begin
                        advance = 1'b1;
                        state_d = ST_LAUNCH;
                    end else begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if ((timeout_lim != '0) && (wdog_q == timeout_lim)) begin
                    tmo_hit = 1'b1;
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state, status flags and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            en_q      <= '0;
            k_q       <= '0;
            fin_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            error     <= 1'b0;
            err_stage <= '0;
            out       <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            fin_q   <= finish | empty_run;
            done    <= fin_q;
            aborted <= abort_hit;
            busy    <= (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
            if (launch_run || empty_run) begin
                en_q  <= stage_en;
                error <= 1'b0;
            end
            if (launch_run) begin
                k_q <= first_idx;
            end else if (advance) begin
                k_q <= adv_idx;
            end
            if (finish) begin
                out <= res_in;
            end
            if (tmo_hit) begin
                error     <= 1'b1;
                err_stage <= k_q;
            end
        end
    end

    // Watchdog and per-stage cycle counters: the strobe cycle counts 1, every wait cycle adds 1, both saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            for (int i = 0; i < N_STAGES; i++) begin
                perf_q[i] <= '0;
            end
        end else if (launch_run || empty_run) begin
            for (int i = 0; i < N_STAGES; i++) begin
                perf_q[i] <= '0;
            end
        end else if ((state_q == ST_LAUNCH) && !abort) begin
            wdog_q <= TMO_W'(1);
            for (int i = 0; i < N_STAGES; i++) begin
                if (k_q == IW'(i)) begin
                    perf_q[i] <= CNT_W'(1);
                end
            end
        end else if ((state_q == ST_WAIT) && !abort) begin
            if (wdog_q != '1) begin
                wdog_q <= wdog_q + TMO_W'(1);
            end
            for (int i = 0; i < N_STAGES; i++) begin
                if ((k_q == IW'(i)) && (perf_q[i] != '1)) begin
                    perf_q[i] <= perf_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Single-cycle start strobe for the current stage while launching.
    always_comb begin
        stage_start = '0;
        if (state_q == ST_LAUNCH) begin
            for (int i = 0; i < N_STAGES; i++) begin
                if (k_q == IW'(i)) begin
                    stage_start[i] = 1'b1;
                end
            end
        end
    end

    // Counter readback mux; a select past the last stage reads 0.
    always_comb begin
        perf_cnt = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (perf_sel == IW'(i)) begin
                perf_cnt = perf_q[i];
            end
        end
    end

endmodule
